memory_readback_fsm: RTL and testbench

- Reader counterpart to the RAM initialisation writer. After the writer signals finish, this block sweeps the same on-chip RAM port, reads every word and checks it against the init pattern (data = low DATA_W bits of address).
- It reports pass/fail, an error count and the first mismatch.
- It streams each read word out for display/debug logic.
- It sits between the RAM read port and the status/display logic.

---
 rtl/memory_test_pkg.sv | 21 ++
 rtl/read_tag_pipe.sv | 37 +++
 rtl/memory_readback_fsm.sv | 125 ++++++++++++
 tb/tb_memory_readback_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_test_pkg.sv
// rtl/memory_test_pkg.sv - shared types, defaults and init pattern for RAM writer/reader
package memory_test_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rb_state_t;

    // Init pattern: each word holds the low data_w bits of its own address
    function automatic logic [31:0] expected_word(input logic [31:0] addr, input int data_w);
        logic [31:0] mask;
        mask = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// rtl/read_tag_pipe.sv - RD_LATENCY-deep {valid, addr} tag shift register tracking RAM reads
module read_tag_pipe #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0] vld;
    logic [ADDR_W-1:0] adr [DEPTH];

    // Shift tags one stage per cycle; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/memory_readback_fsm.sv
// rtl/memory_readback_fsm.sv - sweeps RAM, checks init pattern, streams words and reports errors
module memory_readback_fsm
    import memory_test_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 255,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              rden,
    input  logic [DATA_W-1:0] rddata,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W:0]   ERR_MAX = '1;

    rb_state_t         state;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic              mismatch;
    logic              last_tag;
    logic [ADDR_W:0]   err_next;

    read_tag_pipe #(
        .DEPTH  (RD_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rden),
        .in_addr   (address),
        .out_valid (tag_valid),
        .out_addr  (tag_addr)
    );

    // Compare the retiring read against the pattern and form the saturating error count
    always_comb begin
        mismatch = tag_valid && (rddata != DATA_W'(expected_word(32'(tag_addr), DATA_W)));
        last_tag = tag_valid && (tag_addr == LAST_A);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + 1'b1;
        end
    end

    // Sweep control plus registered compare/stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            address        <= '0;
            rden           <= 1'b0;
            dout           <= '0;
            dout_addr      <= '0;
            dout_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            dout_valid <= tag_valid;
            if (tag_valid) begin
                dout      <= rddata;
                dout_addr <= tag_addr;
            end
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
                first_err_addr <= tag_addr;
                first_err_data <= rddata;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    // No reads are in flight here, so clearing the counters loses nothing
                    if (start) begin
                        state          <= ST_ISSUE;
                        address        <= FIRST_A;
                        rden           <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (address == LAST_A) begin
                        state <= ST_DRAIN;
                        rden  <= 1'b0;
                    end else begin
                        address <= address + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Addresses retire in order, so the last tag marks the end of the sweep
                    if (last_tag) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_readback_fsm.sv
// tb/tb_memory_readback_fsm.sv - self-checking bench for memory_readback_fsm
module tb_memory_readback_fsm;

    localparam int NDUT = 4;
    localparam int LAT_OF   [NDUT] = '{2, 1, 4, 2};
    localparam int FIRST_OF [NDUT] = '{0, 0, 0, 5};
    localparam int LAST_OF  [NDUT] = '{255, 255, 255, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a      [NDUT];
    logic [9:0] address_a    [NDUT];
    logic       rden_a       [NDUT];
    logic [7:0] rddata_a     [NDUT];
    logic [7:0] dout_a       [NDUT];
    logic [9:0] dout_addr_a  [NDUT];
    logic       dout_valid_a [NDUT];
    logic       busy_a       [NDUT];
    logic       done_a       [NDUT];
    logic       pass_a       [NDUT];
    logic [10:0] err_count_a [NDUT];
    logic [9:0] fea_a        [NDUT];
    logic [7:0] fed_a        [NDUT];

    logic [7:0] mem [1024];

    int nassert = 0;
    int nfail   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int LAT = (g == 1) ? 1 : (g == 2) ? 4 : 2;
        localparam int FA  = (g == 3) ? 5 : 0;
        localparam int LA  = (g == 3) ? 5 : 255;
        logic [7:0] rp [4];

        memory_readback_fsm #(
            .ADDR_W(10), .DATA_W(8), .FIRST_ADDR(FA), .LAST_ADDR(LA), .RD_LATENCY(LAT)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start_a[g]),
            .address        (address_a[g]),
            .rden           (rden_a[g]),
            .rddata         (rddata_a[g]),
            .dout           (dout_a[g]),
            .dout_addr      (dout_addr_a[g]),
            .dout_valid     (dout_valid_a[g]),
            .busy           (busy_a[g]),
            .done           (done_a[g]),
            .pass           (pass_a[g]),
            .err_count      (err_count_a[g]),
            .first_err_addr (fea_a[g]),
            .first_err_data (fed_a[g])
        );

        // RAM read port: data appears LAT cycles after rden; garbage when not read
        always @(posedge clk) begin
            rp[0] <= rden_a[g] ? mem[address_a[g]] : 8'($urandom);
            for (int j = 1; j < 4; j++) rp[j] <= rp[j-1];
        end
        assign rddata_a[g] = rp[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_good();
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    endtask

    task automatic check_all_zero(input int g, input string tag);
        logic [31:0] agg;
        agg = 32'(address_a[g]) | 32'(rden_a[g]) | 32'(dout_a[g]) | 32'(dout_addr_a[g])
            | 32'(dout_valid_a[g]) | 32'(busy_a[g]) | 32'(done_a[g]) | 32'(pass_a[g])
            | 32'(err_count_a[g]) | 32'(fea_a[g]) | 32'(fed_a[g]);
        check(tag, agg, 32'd0);
    endtask

    // Start at edge 0 (cycle numbering: values visible after edge e are cycle e+1);
    // s0/s1 are extra start pulses sampled at those edges, which must be ignored
    task automatic run_sweep(input int g, input string tag, input int s0, input int s1);
        int first, last, lat, n, errs, ferr_a, ferr_d;
        int nxt, nstrobe, nrden, done_cyc, last_strobe_cyc;
        first = FIRST_OF[g];
        last  = LAST_OF[g];
        lat   = LAT_OF[g];
        n     = last - first + 1;
        errs = 0; ferr_a = 0; ferr_d = 0;
        for (int a = first; a <= last; a++) begin
            if (mem[a] != 8'(a)) begin
                if (errs == 0) begin
                    ferr_a = a;
                    ferr_d = mem[a];
                end
                errs++;
            end
        end
        nxt = first; nstrobe = 0; nrden = 0; done_cyc = -1; last_strobe_cyc = -1;
        start_a[g] = 1'b1;
        tick();
        for (int cyc = 1; cyc <= n + lat + 10; cyc++) begin
            start_a[g] = (cyc == s0 || cyc == s1);
            if (cyc == 1) begin
                check({tag, " done_drop"}, 32'(done_a[g]), 32'd0);
                check({tag, " busy_rise"}, 32'(busy_a[g]), 32'd1);
                check({tag, " err_clear"}, 32'(err_count_a[g]), 32'd0);
            end
            if (rden_a[g]) nrden++;
            if (dout_valid_a[g]) begin
                if (nxt <= last) begin
                    check({tag, " dout_addr"}, 32'(dout_addr_a[g]), 32'(nxt));
                    check({tag, " dout"}, 32'(dout_a[g]), 32'(mem[nxt]));
                end
                nxt++;
                nstrobe++;
                last_strobe_cyc = cyc;
            end
            if (done_a[g] && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        start_a[g] = 1'b0;
        check({tag, " rden_count"}, 32'(nrden), 32'(n));
        check({tag, " strobes"}, 32'(nstrobe), 32'(n));
        check({tag, " last_strobe_cyc"}, 32'(last_strobe_cyc), 32'(n + lat + 1));
        check({tag, " done_cyc"}, 32'(done_cyc), 32'(n + lat + 1));
        check({tag, " done_hold"}, 32'(done_a[g]), 32'd1);
        check({tag, " busy_end"}, 32'(busy_a[g]), 32'd0);
        check({tag, " err_count"}, 32'(err_count_a[g]), 32'(errs));
        check({tag, " pass"}, 32'(pass_a[g]), 32'(errs == 0));
        check({tag, " first_err_addr"}, 32'(fea_a[g]), 32'(ferr_a));
        check({tag, " first_err_data"}, 32'(fed_a[g]), 32'(ferr_d));
    endtask

    initial begin
        int k, ra;
        fill_good();
        for (int g = 0; g < NDUT; g++) start_a[g] = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) check_all_zero(g, "reset_state");
        rst_n = 1'b1;
        repeat (2) tick();

        // Good RAM, starts while busy and on the final-compare edge are ignored
        run_sweep(0, "good", 50, 258);
        repeat (5) tick();
        // Restart from DONE (second start while busy at 257) gives identical results
        run_sweep(0, "again", 257, -1);

        // Directed corruption
        mem[17]  = 8'hAA;
        mem[200] = 8'h00;
        run_sweep(0, "corrupt", -1, -1);
        check("corrupt_const_count", 32'(err_count_a[0]), 32'd2);
        check("corrupt_const_addr", 32'(fea_a[0]), 32'd17);
        check("corrupt_const_data", 32'(fed_a[0]), 32'hAA);
        fill_good();

        // Randomized corruption against the reference scan
        for (int r = 0; r < 2; r++) begin
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                ra = $urandom_range(0, 255);
                mem[ra] = 8'(ra) ^ 8'($urandom_range(1, 255));
            end
            run_sweep(0, "random", -1, -1);
            fill_good();
        end

        // Reset mid-sweep: start at edge 0, reset sampled at edge 100
        start_a[0] = 1'b1;
        tick();
        start_a[0] = 1'b0;
        for (int cyc = 1; cyc < 100; cyc++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero(0, "midreset_zero");
        begin
            int nv;
            nv = 0;
            for (int i = 0; i < 8; i++) begin
                if (dout_valid_a[0] || busy_a[0] || rden_a[0]) nv++;
                tick();
            end
            check("midreset_quiet", 32'(nv), 32'd0);
        end
        run_sweep(0, "post_reset", -1, -1);

        // Other latencies and the single-word sweep
        run_sweep(1, "lat1", -1, -1);
        run_sweep(2, "lat4", -1, -1);
        run_sweep(3, "single", -1, -1);
        check("single_dout", 32'(dout_a[3]), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
